// File: rtl/sseg_scan_pkg.sv
// Shared constants, types and helpers for the multiplexed seven-segment scanner.
package sseg_scan_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int NUM_PHASES = 8;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int PHASE_W    = $clog2(NUM_PHASES);

    localparam logic [6:0]            SEG_OFF = 7'h7f;
    localparam logic [NUM_DIGITS-1:0] DIG_OFF = 4'hf;

    typedef logic [6:0]            seg_t;
    typedef logic [NUM_DIGITS-1:0] dig_t;

    // Pattern and brightness captured for the digit currently being scanned.
    typedef struct packed {
        seg_t             pat;
        logic [PHASE_W-1:0] level;
    } slot_t;

    // Phase 0 is always blanking, so idx may change there without ghosting.
    function automatic logic slot_lit(input logic [PHASE_W-1:0] phase,
                                      input logic [PHASE_W-1:0] level);
        return (phase != '0) && (phase <= level);
    endfunction

endpackage

// File: rtl/sseg_scan_timebase.sv
// Step/phase/digit counters for the display scan; strobes mark slot and frame boundaries.
module sseg_scan_timebase
    import sseg_scan_pkg::*;
#(
    parameter int STEP   = 256,
    parameter int STEP_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    output logic [PHASE_W-1:0] phase,
    output logic [IDX_W-1:0]   idx,
    output logic [IDX_W-1:0]   idx_upcoming,
    output logic               slot_start,
    output logic               frame_start
);

    logic [STEP_W-1:0]  step_reg,  step_next;
    logic [PHASE_W-1:0] phase_reg, phase_next;
    logic [IDX_W-1:0]   idx_reg,   idx_next;
    logic               step_wrap;

    assign step_wrap   = (step_reg == STEP_W'(STEP - 1));
    assign slot_start  = step_wrap && (phase_reg == PHASE_W'(NUM_PHASES - 1));
    assign frame_start = slot_start && (idx_reg == IDX_W'(NUM_DIGITS - 1));

    always_comb begin
        step_next  = step_wrap ? '0 : step_reg + 1'b1;
        phase_next = step_wrap ? phase_reg + 1'b1 : phase_reg;
        idx_next   = slot_start ? idx_reg + 1'b1 : idx_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_reg  <= '0;
            phase_reg <= '0;
            idx_reg   <= '0;
        end else begin
            step_reg  <= step_next;
            phase_reg <= phase_next;
            idx_reg   <= idx_next;
        end
    end

    assign phase        = phase_reg;
    assign idx          = idx_reg;
    assign idx_upcoming = idx_reg + 1'b1;

endmodule

// File: rtl/sseg_scan_mux.sv
// Time-multiplexes four static segment patterns onto a shared bus with blanking and PWM dimming.
module sseg_scan_mux
    import sseg_scan_pkg::*;
#(
    parameter int STEP   = 256,
    parameter int STEP_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] hex_0,
    input  logic [6:0] hex_1,
    input  logic [6:0] hex_2,
    input  logic [6:0] hex_3,
    input  logic [2:0] bright,
    output logic [6:0] seg_n,
    output logic [3:0] dig_n,
    output logic       frame
);

    logic [PHASE_W-1:0] phase;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W-1:0]   idx_upcoming;
    logic               slot_start;
    logic               frame_start;

    sseg_scan_timebase #(
        .STEP   (STEP),
        .STEP_W (STEP_W)
    ) u_timebase (
        .clk          (clk),
        .rst          (rst),
        .phase        (phase),
        .idx          (idx),
        .idx_upcoming (idx_upcoming),
        .slot_start   (slot_start),
        .frame_start  (frame_start)
    );

    seg_t  hex_arr [NUM_DIGITS];
    slot_t slot_reg;
    dig_t  dig_sel;
    logic  lit;
    seg_t  seg_reg;
    dig_t  dig_reg;
    logic  frame_reg;

    assign hex_arr[0] = hex_0;
    assign hex_arr[1] = hex_1;
    assign hex_arr[2] = hex_2;
    assign hex_arr[3] = hex_3;

    // Capture on the same edge that advances idx, so the slot always shows its own digit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_reg <= '{pat: SEG_OFF, level: '0};
        end else if (slot_start) begin
            slot_reg <= '{pat: hex_arr[idx_upcoming], level: bright};
        end
    end

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dig_sel
        assign dig_sel[gi] = (idx == IDX_W'(gi));
    end

    assign lit = slot_lit(phase, slot_reg.level);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_reg   <= SEG_OFF;
            dig_reg   <= DIG_OFF;
            frame_reg <= 1'b0;
        end else begin
            seg_reg   <= lit ? slot_reg.pat : SEG_OFF;
            dig_reg   <= lit ? ~dig_sel : DIG_OFF;
            frame_reg <= frame_start;
        end
    end

    assign seg_n = seg_reg;
    assign dig_n = dig_reg;
    assign frame = frame_reg;

endmodule

// File: tb/tb_sseg_scan_mux.sv
// Directed and random checks of sseg_scan_mux against a cycle-count reference model (STEP = 2).
module tb_sseg_scan_mux;

    localparam int STEP  = 2;
    localparam int SLOT  = 8 * STEP;
    localparam int FRAME = 4 * SLOT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [6:0] hex [4];
    logic [2:0] bright;
    logic [6:0] seg_n;
    logic [3:0] dig_n;
    logic       frame;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state: cycles since reset release and the values latched for this slot.
    int         n;
    logic [6:0] m_pat;
    logic [2:0] m_br;
    logic [3:0] prev_dig;
    int         last_frame_n;

    sseg_scan_mux #(
        .STEP   (STEP),
        .STEP_W (1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .hex_0  (hex[0]),
        .hex_1  (hex[1]),
        .hex_2  (hex[2]),
        .hex_3  (hex[3]),
        .bright (bright),
        .seg_n  (seg_n),
        .dig_n  (dig_n),
        .frame  (frame)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    task automatic tick();
        int         ph;
        int         id;
        logic       lit;
        logic [6:0] e_seg;
        logic [3:0] e_dig;
        logic       e_frame;
        ph      = (n / STEP) % 8;
        id      = (n / SLOT) % 4;
        lit     = (ph != 0) && (ph <= int'(m_br));
        e_seg   = lit ? m_pat : 7'h7f;
        e_dig   = lit ? ~(4'b0001 << id) : 4'hf;
        e_frame = ((n % FRAME) == FRAME - 1);
        if ((n % SLOT) == SLOT - 1) begin
            m_pat = hex[(id + 1) % 4];
            m_br  = bright;
        end
        @(posedge clk);
        n++;
        @(negedge clk);
        chk("seg_n", 32'(seg_n), 32'(e_seg));
        chk("dig_n", 32'(dig_n), 32'(e_dig));
        chk("frame", 32'(frame), 32'(e_frame));
        chk("dig_onehot0", 32'($countones(~dig_n) <= 1), 32'd1);
        if (prev_dig != 4'hf && dig_n != 4'hf)
            chk("dig_no_direct_switch", 32'(dig_n), 32'(prev_dig));
        if (frame) begin
            if (last_frame_n >= 0)
                chk("frame_period", 32'(n - last_frame_n), 32'(FRAME));
            last_frame_n = n;
        end
        prev_dig = dig_n;
    endtask

    task automatic do_reset(input int hold);
        rst = 1'b1;
        #1;
        chk("rst_seg_n", 32'(seg_n), 32'h7f);
        chk("rst_dig_n", 32'(dig_n), 32'hf);
        chk("rst_frame", 32'(frame), 32'h0);
        repeat (hold) @(negedge clk);
        rst          = 1'b0;
        n            = 0;
        m_pat        = 7'h7f;
        m_br         = 3'd0;
        prev_dig     = 4'hf;
        last_frame_n = -1;
    endtask

    task automatic align_slot();
        do tick(); while ((n % SLOT) != 0);
    endtask

    // First slot after reset is dark; digit 1 then lights 14 of 16 cycles.
    task automatic startup_checks(input string tag);
        int cnt;
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (dig_n != 4'hf) cnt++;
        end
        chk({tag, "_first_slot_dark"}, 32'(cnt), 32'd0);
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (dig_n == 4'b1101 && seg_n == 7'h79) cnt++;
        end
        chk({tag, "_digit1_lit_cycles"}, 32'(cnt), 32'd14);
    endtask

    initial begin
        int cnt;
        int per_dig [4];
        int bound;
        hex[0] = 7'h40; hex[1] = 7'h79; hex[2] = 7'h24; hex[3] = 7'h30;
        bright = 3'd7;
        n = 0; m_pat = 7'h7f; m_br = 3'd0; prev_dig = 4'hf; last_frame_n = -1;
        @(negedge clk);

        // 1: reset and startup
        do_reset(3);
        startup_checks("s1");

        // 2: brightness 0 then 1
        bright = 3'd0;
        align_slot();
        cnt = 0;
        repeat (FRAME) begin
            tick();
            if (dig_n != 4'hf) cnt++;
        end
        chk("s2_bright0_lit_cycles", 32'(cnt), 32'd0);
        bright = 3'd1;
        align_slot();
        per_dig = '{0, 0, 0, 0};
        repeat (FRAME) begin
            tick();
            for (int d = 0; d < 4; d++)
                if (dig_n[d] == 1'b0) per_dig[d]++;
        end
        for (int d = 0; d < 4; d++)
            chk($sformatf("s2_bright1_digit%0d_cycles", d), 32'(per_dig[d]), 32'd2);

        // 3: mid-slot change of hex_2
        bright = 3'd7;
        align_slot();
        while (!(((n / SLOT) % 4) == 2 && (n % SLOT) == 8)) tick();
        hex[2] = 7'h12;
        cnt = 0;
        do begin
            tick();
            if (dig_n == 4'b1011 && seg_n == 7'h24) cnt++;
        end while ((n % SLOT) != 0);
        chk("s3_old_pattern_held", 32'(cnt), 32'd8);
        while (((n / SLOT) % 4) != 2 || (n % SLOT) != 0) tick();
        cnt = 0;
        repeat (SLOT) begin
            tick();
            if (dig_n == 4'b1011 && seg_n == 7'h12) cnt++;
        end
        chk("s3_new_pattern_next_slot", 32'(cnt), 32'd14);

        // 4: frame monitoring across several frames
        cnt = 0;
        repeat (3 * FRAME) begin
            tick();
            if (frame) cnt++;
        end
        chk("s4_frame_pulses", 32'(cnt), 32'd3);

        // 5: reset pulse while digit 3 is lit
        bound = 0;
        while (dig_n != 4'b0111 && bound < 2 * FRAME) begin
            tick();
            bound++;
        end
        chk("s5_reached_digit3", 32'(dig_n), 32'h7);
        hex[2] = 7'h24;
        do_reset(1);
        startup_checks("s5");

        // 6: random inputs
        repeat (10000) begin
            for (int d = 0; d < 4; d++) hex[d] = 7'($urandom);
            bright = 3'($urandom_range(0, 7));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
